// File: rtl/rv32_pkg.sv
// Shared RV32 constants: instruction-format codes, base opcodes, NOP word,
// fetch FSM encoding and the IF/ID slot layout.
package rv32_pkg;

    localparam logic [2:0] I_TYPE = 3'b000;
    localparam logic [2:0] S_TYPE = 3'b001;
    localparam logic [2:0] B_TYPE = 3'b010;
    localparam logic [2:0] U_TYPE = 3'b011;
    localparam logic [2:0] J_TYPE = 3'b100;
    localparam logic [2:0] R_TYPE = 3'b101;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  instr_type;
        logic        illegal;
    } if_id_t;

endpackage

// File: rtl/instr_type_decode.sv
// Opcode -> instruction format classifier, shared with the decode stage.
// FETCH_ILLEGAL_CHECK_EN enables flagging of unrecognised opcodes.
module instr_type_decode
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  instr_type,
    output logic        illegal
);

    // Only the opcode field participates in classification.
    logic unused_bits;
    assign unused_bits = ^instr[31:7];

    always_comb begin
        instr_type = I_TYPE;
        illegal    = 1'b0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC:                          instr_type = U_TYPE;
            OP_JAL:                                    instr_type = J_TYPE;
            OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM,
            OP_SYSTEM:                                 instr_type = I_TYPE;
            OP_STORE:                                  instr_type = S_TYPE;
            OP_BRANCH:                                 instr_type = B_TYPE;
            OP_OP:                                     instr_type = R_TYPE;
            default: begin
                // Every listed opcode ends in 2'b11, so this also catches
                // compressed/non-32-bit encodings.
                instr_type = I_TYPE;
`ifdef FETCH_ILLEGAL_CHECK_EN
                illegal    = 1'b1;
`else
                illegal    = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: PC, single-outstanding imem req/gnt/rvalid port, and a
// registered IF/ID slot. Optional: FETCH_ILLEGAL_CHECK_EN (via decoder).
module instr_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [2:0]  id_instr_type,
    output logic        id_illegal
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_pending_q, req_pending_d;
    logic         discard_q, discard_d;
    logic         load;
    logic         slot_free;
    logic         req_fire;
    logic [31:0]  redirect_aligned;
    logic [2:0]   dec_type;
    logic         dec_illegal;
    logic         id_valid_q;
    if_id_t       slot_q;

    instr_type_decode u_dec (
        .instr      (imem_rdata),
        .instr_type (dec_type),
        .illegal    (dec_illegal)
    );

    assign slot_free        = !id_valid_q || id_ready;
    assign req_fire         = imem_req && imem_gnt;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            req_pending_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pending_q <= req_pending_d;
            discard_q     <= discard_d;
        end
    end

    // Next-state logic; redirect outranks every other event.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pending_d = req_pending_q;
        discard_d     = discard_q;
        load          = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d          = redirect_aligned;
                    req_pending_d = 1'b0;
                    if (req_fire) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end else if (req_fire) begin
                    state_d       = S_WAIT;
                    req_pending_d = 1'b0;
                end else if (imem_req) begin
                    req_pending_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                    // A response arriving with the redirect is the one being
                    // dropped, so there is nothing left to wait for.
                    if (imem_rvalid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_d   = S_REQ;
                    discard_d = 1'b0;
                    if (!discard_q) begin
                        load = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Outputs; request stays low while reset is held.
    always_comb begin
        imem_req  = !rst && (state_q == S_REQ) && (slot_free || req_pending_q);
        imem_addr = pc_q;
    end

    // IF/ID slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            slot_q     <= '{instr: NOP_INSTR, pc: 32'h0, instr_type: I_TYPE, illegal: 1'b0};
        end else if (redirect_valid) begin
            id_valid_q <= 1'b0;
        end else if (load) begin
            id_valid_q <= 1'b1;
            slot_q     <= '{instr: imem_rdata, pc: pc_q, instr_type: dec_type, illegal: dec_illegal};
        end else if (id_ready) begin
            id_valid_q <= 1'b0;
        end
    end

    assign id_valid      = id_valid_q;
    assign id_instr      = slot_q.instr;
    assign id_pc         = slot_q.pc;
    assign id_instr_type = slot_q.instr_type;
    assign id_illegal    = slot_q.illegal;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a behavioural
// memory/program model; expectations queued at grant, checked at handshake.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  id_instr_type;
    logic        id_illegal;

`ifdef FETCH_ILLEGAL_CHECK_EN
    localparam bit CHK_ILL = 1'b1;
`else
    localparam bit CHK_ILL = 1'b0;
`endif

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_instr_type  (id_instr_type),
        .id_illegal     (id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  ty;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          hs_cnt = 0;

    // model state
    bit          outst;
    int          cnt;
    logic [31:0] out_addr;
    logic [31:0] model_pc;
    bit          pend;
    int          stall_left;
    int          gnt_hold;
    bit          force_rd;
    bit          exp100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Program image: fixed vectors at the bottom, hashed words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0]  ops [14] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23,
                                  7'h13, 7'h33, 7'h0f, 7'h73, 7'h00, 7'h7f, 7'h53};
        logic [31:0] h;
        case (a)
            32'd0:  return 32'h5dc00093;
            32'd4:  return 32'h001127a3;
            32'd8:  return 32'hfe208ee3;
            32'd12: return 32'h001000b7;
            32'd16: return 32'h000010ef;
            32'd20: return 32'h002081b3;
            32'd24: return 32'h00000000;
            default: begin
                h = (a * 32'h9E3779B1) ^ 32'h5bd1e995;
                h = h ^ (h >> 15);
                return {h[31:7], ops[h[27:24] % 14]};
            end
        endcase
    endfunction

    // Format classification straight from the RV32I base opcode map.
    task automatic ref_decode(input logic [31:0] w, output logic [2:0] ty, output logic ill);
        logic [6:0] opc [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h0f,
                                 7'h73, 7'h23, 7'h63, 7'h33};
        logic [2:0] fmt [11] = '{3'd3, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd0, 3'd1, 3'd2, 3'd5};
        bit found = 0;
        ty = 3'd0;
        for (int i = 0; i < 11; i++)
            if (w[6:0] == opc[i]) begin
                found = 1;
                ty = fmt[i];
            end
        ill = CHK_ILL && !found;
    endtask

    task automatic run(input int n, input int gnt_pct, input int rdy_pct,
                       input int rd_pct, input int maxd);
        exp_t e;
        bit   exp_req;
        for (int c = 0; c < n; c++) begin
            // drive inputs at the falling edge
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (outst) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(out_addr);
                end
            end
            imem_gnt = ($urandom_range(99) < gnt_pct);
            if (gnt_hold > 0) imem_gnt = 1'b0;
            if (stall_left > 0 && id_valid) id_ready = 1'b0;
            else                            id_ready = ($urandom_range(99) < rdy_pct);
            redirect_valid = ($urandom_range(99) < rd_pct);
            redirect_pc    = $urandom;
            if (force_rd && outst) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0103;
                force_rd       = 0;
                exp100         = 1;
            end
            #1;
            exp_req = !outst && (!id_valid || id_ready || pend);
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            if (imem_req) chk("imem_addr", imem_addr, model_pc);
            if (gnt_hold > 0 && imem_req) gnt_hold--;
            if (stall_left > 0 && id_valid && !id_ready) stall_left--;
            if (imem_req && imem_gnt) begin
                if (exp100) begin
                    chk("redirect_addr", imem_addr, 32'h0000_0100);
                    exp100 = 0;
                end
                e.pc    = model_pc;
                e.instr = mem_word(model_pc);
                ref_decode(e.instr, e.ty, e.ill);
                q.push_back(e);
                outst    = 1;
                cnt      = $urandom_range(maxd, 1);
                out_addr = model_pc;
                model_pc = model_pc + 32'd4;
                pend     = 0;
            end else if (imem_req) begin
                pend = 1;
            end
            if (imem_rvalid) outst = 0;
            if (redirect_valid) begin
                model_pc = {redirect_pc[31:2], 2'b00};
                pend     = 0;
                q.delete();
            end
            @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted slot.
    initial begin
        exp_t        e;
        bit          hold_chk = 0;
        bit          flush_chk = 0;
        logic [31:0] s_instr, s_pc;
        logic [2:0]  s_ty;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_chk  = 0;
                flush_chk = 0;
            end else begin
                if (flush_chk) chk("flush_valid", {31'd0, id_valid}, 32'd0);
                if (hold_chk) begin
                    chk("stall_valid", {31'd0, id_valid}, 32'd1);
                    chk("stall_instr", id_instr, s_instr);
                    chk("stall_pc", id_pc, s_pc);
                    chk("stall_type", {29'd0, id_instr_type}, {29'd0, s_ty});
                end
                hold_chk  = id_valid && !id_ready && !redirect_valid;
                flush_chk = redirect_valid;
                s_instr = id_instr;
                s_pc    = id_pc;
                s_ty    = id_instr_type;
                if (id_valid && id_ready && !redirect_valid) begin
                    hs_cnt++;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_id: got pc %h with no pending fetch", id_pc);
                    end else begin
                        e = q.pop_front();
                        chk("id_pc", id_pc, e.pc);
                        chk("id_instr", id_instr, e.instr);
                        chk("id_type", {29'd0, id_instr_type}, {29'd0, e.ty});
                        chk("id_illegal", {31'd0, id_illegal}, {31'd0, e.ill});
                    end
                end
            end
        end
    end

    initial begin
        int hs0;
        rst = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; id_ready = 0;
        outst = 0; cnt = 0; out_addr = 0; model_pc = 0; pend = 0;
        stall_left = 0; gnt_hold = 0; force_rd = 0; exp100 = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_type", {29'd0, id_instr_type}, 32'd0);
        chk("rst_illegal", {31'd0, id_illegal}, 32'd0);
        rst = 1'b0;

        // 1-cycle memory, always ready: one instruction every 2 cycles
        hs0 = hs_cnt;
        run(24, 100, 100, 0, 1);
        chk("throughput", hs_cnt - hs0, 32'd11);

        stall_left = 5;
        run(20, 100, 100, 0, 1);
        gnt_hold = 3;
        run(15, 100, 100, 0, 1);
        force_rd = 1;
        run(20, 100, 100, 0, 3);
        chk("redirect_seen", {31'd0, exp100 | force_rd}, 32'd0);

        run(3000, 70, 70, 4, 3);
        run(20, 100, 100, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
